// File: rtl/video_pkg.sv
// Shared video definitions for the DDR pixel writer and the frame reader.
// Both blocks agree on the pixel format, the 5-pixels-per-word packing and
// the number of words a frame occupies in DDR.
package video_pkg;

    localparam int PIXEL_W         = 24;
    localparam int PIXELS_PER_WORD = 5;
    localparam int SLOT_W          = $clog2(PIXELS_PER_WORD);

    typedef logic [PIXEL_W-1:0] pixel_t;

    // Writer control states; the reader waits for end_of_write before reading.
    typedef enum logic [1:0] {
        PACK     = 2'd0,
        WAIT_BUS = 2'd1,
        ISSUE    = 2'd2,
        DONE     = 2'd3
    } writer_state_t;

    // DDR words per frame: a partially filled last word still takes a full word.
    function automatic int words_per_frame(input int n);
        return (n + PIXELS_PER_WORD - 1) / PIXELS_PER_WORD;
    endfunction

endpackage

// File: rtl/pixel_packer_writer_if.sv
// Pixel stream in, DDR single-word write requests out.
// The writer side (master) drives the DDR request and the pixel handshake
// ready; the environment side (slave) supplies pixels and the DDR busy flag.
interface pixel_packer_writer_if
    import video_pkg::*;
#(
    parameter int DDR_DATA_WIDTH = 128,
    parameter int ADDR_WIDTH     = 24
);

    pixel_t                    pixel_in;
    logic                      pixel_valid;
    logic                      pixel_ready;
    logic                      ddr_wr_busy;
    logic                      ddr_wr_en;
    logic [DDR_DATA_WIDTH-1:0] ddr_wr_data;
    logic [ADDR_WIDTH-1:0]     ddr_addr;
    logic                      frame_done;
    logic                      end_of_write;

    modport master (
        input  pixel_in,
        input  pixel_valid,
        output pixel_ready,
        input  ddr_wr_busy,
        output ddr_wr_en,
        output ddr_wr_data,
        output ddr_addr,
        output frame_done,
        output end_of_write
    );

    modport slave (
        output pixel_in,
        output pixel_valid,
        input  pixel_ready,
        output ddr_wr_busy,
        input  ddr_wr_en,
        input  ddr_wr_data,
        input  ddr_addr,
        input  frame_done,
        input  end_of_write
    );

endinterface

// File: rtl/pixel_packer_writer_packer.sv
// Five-slot pixel accumulator. Slot k sits at bits [24k+23:24k] of the DDR
// word; bits above the last slot and any slot not yet written read as zero.
module pixel_word_packer
    import video_pkg::*;
#(
    parameter int DDR_DATA_WIDTH = 128
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic                      clear,
    input  pixel_t                    pixel,
    output logic [DDR_DATA_WIDTH-1:0] word,
    output logic                      full
);

    pixel_t              slots_q [PIXELS_PER_WORD];
    logic [SLOT_W-1:0]   slot_q;

    // Write the incoming pixel into the current slot; clear empties the word.
    // NOTE: this is five flops wide, not a RAM, so it takes the async reset;
    // a stale slot must never leak into a partially filled word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= '0;
            for (int k = 0; k < PIXELS_PER_WORD; k++) slots_q[k] <= '0;
        end else if (clear) begin
            slot_q <= '0;
            for (int k = 0; k < PIXELS_PER_WORD; k++) slots_q[k] <= '0;
        end else if (load) begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            slots_q[slot_q] <= pixel;
            slot_q          <= slot_q + 1'b1;
        end
    end

    // Lay the slots out in the DDR word, zero-filling the spare top bits.
    always_comb begin
        // NOTE: default first, so no path leaves word unassigned (no latch).
        word = '0;
        for (int k = 0; k < PIXELS_PER_WORD; k++) begin
            word[k*PIXEL_W +: PIXEL_W] = slots_q[k];
        end
    end

    // The next load fills the last slot of the word.
    assign full = (slot_q == SLOT_W'(PIXELS_PER_WORD - 1));

endmodule

// File: rtl/pixel_packer_writer.sv
// Packs a 24-bit RGB pixel stream five to a 128-bit DDR word and writes the
// words to consecutive addresses, frame after frame. A frame whose pixel
// count is not a multiple of five ends with a partially filled word.
// end_of_write is raised once the last word of the last frame is written.
module pixel_packer_writer
    import video_pkg::*;
#(
    parameter int DDR_DATA_WIDTH   = 128,
    parameter int NUMBER_OF_PIXELS = 196608,
    parameter int NUMBER_OF_FRAMES = 8,
    parameter int ADDR_WIDTH       = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    pixel_packer_writer_if.master bus
);

    localparam int PN_W = $clog2(NUMBER_OF_PIXELS + 1);
    localparam int FC_W = $clog2(NUMBER_OF_FRAMES + 1);

    localparam logic [PN_W-1:0] LAST_PIXEL   = PN_W'(NUMBER_OF_PIXELS - 1);
    localparam logic [PN_W-1:0] FRAME_PIXELS = PN_W'(NUMBER_OF_PIXELS);
    localparam logic [FC_W-1:0] LAST_FRAME   = FC_W'(NUMBER_OF_FRAMES - 1);

    localparam longint unsigned TOTAL_WORDS =
        longint'(NUMBER_OF_FRAMES) * longint'(words_per_frame(NUMBER_OF_PIXELS));
    localparam longint unsigned ADDR_SPACE = 64'd1 << ADDR_WIDTH;

    // The whole clip must fit without the word address wrapping.
    if (TOTAL_WORDS > ADDR_SPACE) begin : g_addr_space_check
        $error("pixel_packer_writer: clip does not fit in the DDR address space");
    end

    writer_state_t             state_q, state_d;
    logic [PN_W-1:0]           pixel_number_q;
    logic [FC_W-1:0]           frame_count_q;
    logic [ADDR_WIDTH-1:0]     addr_q;
    logic                      ready_q;
    logic                      wr_en_q;
    logic                      frame_done_q;
    logic                      end_of_write_q;

    logic                      transfer;
    logic                      load;
    logic                      clear;
    logic                      word_full;
    logic                      last_pixel;
    logic                      frame_last_word;
    logic                      last_frame;
    logic [DDR_DATA_WIDTH-1:0] word;

    pixel_word_packer #(
        .DDR_DATA_WIDTH (DDR_DATA_WIDTH)
    ) u_packer (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .clear (clear),
        .pixel (bus.pixel_in),
        .word  (word),
        .full  (word_full)
    );

    assign transfer        = bus.pixel_valid && ready_q;
    assign last_pixel      = (pixel_number_q == LAST_PIXEL);
    // Once the last pixel has been counted, the word in flight ends the frame.
    assign frame_last_word = (pixel_number_q == FRAME_PIXELS);
    assign last_frame      = (frame_count_q == LAST_FRAME);

    // Next-state logic: pack, wait for the controller, issue one write.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            PACK: begin
                if (transfer) begin
                    load = 1'b1;
                    if (word_full || last_pixel) state_d = WAIT_BUS;
                end
            end
            WAIT_BUS: begin
                if (!bus.ddr_wr_busy) state_d = ISSUE;
            end
            ISSUE: begin
                // The request is already on the bus; busy is not sampled here.
                clear   = 1'b1;
                state_d = (frame_last_word && last_frame) ? DONE : PACK;
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = PACK;
            end
        endcase
    end

    // State register plus the registered handshake outputs derived from it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PACK;
            ready_q <= 1'b0;
            wr_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == PACK);
            wr_en_q <= (state_d == ISSUE);
        end
    end

    // Pixel, frame and address counters, advanced on transfers and writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel_number_q <= '0;
            frame_count_q  <= '0;
            addr_q         <= '0;
            frame_done_q   <= 1'b0;
            end_of_write_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (load) pixel_number_q <= pixel_number_q + 1'b1;
            if (state_q == ISSUE) begin
                addr_q <= addr_q + 1'b1;
                if (frame_last_word) begin
                    pixel_number_q <= '0;
                    frame_count_q  <= frame_count_q + 1'b1;
                    frame_done_q   <= 1'b1;
                    if (last_frame) end_of_write_q <= 1'b1;
                end
            end
        end
    end

    assign bus.pixel_ready  = ready_q;
    assign bus.ddr_wr_en    = wr_en_q;
    assign bus.ddr_wr_data  = word;
    assign bus.ddr_addr     = addr_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.end_of_write = end_of_write_q;

endmodule

// File: tb/tb_pixel_packer_writer.sv
// Directed bench for pixel_packer_writer. Instance A is a 12-pixel, 2-frame
// clip (three words per frame, last word holding two pixels); instance B is
// a 1003-pixel, 1-frame clip whose last word holds three pixels, the same
// shape as the full 512x384 frame.
module tb_pixel_packer_writer;
    import video_pkg::*;

    logic clk;
    logic a_reset;
    logic b_reset;

    int tests;
    int fails;

    pixel_packer_writer_if #(.DDR_DATA_WIDTH(128), .ADDR_WIDTH(24)) a_if ();
    pixel_packer_writer_if #(.DDR_DATA_WIDTH(128), .ADDR_WIDTH(24)) b_if ();

    pixel_packer_writer #(
        .DDR_DATA_WIDTH   (128),
        .NUMBER_OF_PIXELS (12),
        .NUMBER_OF_FRAMES (2),
        .ADDR_WIDTH       (24)
    ) dut_a (
        .clk   (clk),
        .reset (a_reset),
        .bus   (a_if)
    );

    pixel_packer_writer #(
        .DDR_DATA_WIDTH   (128),
        .NUMBER_OF_PIXELS (1003),
        .NUMBER_OF_FRAMES (1),
        .ADDR_WIDTH       (24)
    ) dut_b (
        .clk   (clk),
        .reset (b_reset),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word holding n consecutive pixel values starting at first.
    function automatic logic [127:0] pack(input int first, input int n);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[24*k +: 24] = 24'(first + k);
        return w;
    endfunction

    task automatic check(input string tag, input logic [127:0] observed,
                         input logic [127:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // ---------------- write monitors (sampled on the falling edge) --------
    logic [23:0]  a_addr_q [$];
    logic [127:0] a_data_q [$];
    int           a_fd_count;
    bit           a_fd_ok;
    logic [23:0]  a_fd_addr;
    bit           a_prev_wr;
    bit           a_prev_eow;
    int           a_eow_rises;
    logic [23:0]  a_eow_addr;
    bit           a_eow_after_wr;

    always @(negedge clk) begin
        if (a_reset) begin
            a_addr_q.delete();
            a_data_q.delete();
            a_fd_count     = 0;
            a_fd_ok        = 1'b1;
            a_fd_addr      = '1;
            a_prev_wr      = 1'b0;
            a_prev_eow     = 1'b0;
            a_eow_rises    = 0;
            a_eow_addr     = '1;
            a_eow_after_wr = 1'b0;
        end else begin
            if (a_if.frame_done) begin
                a_fd_count++;
                if (!a_prev_wr) a_fd_ok = 1'b0;
                if (a_addr_q.size() > 0) a_fd_addr = a_addr_q[a_addr_q.size()-1];
            end
            if (a_if.end_of_write && !a_prev_eow) begin
                a_eow_rises++;
                a_eow_after_wr = a_prev_wr;
                if (a_addr_q.size() > 0) a_eow_addr = a_addr_q[a_addr_q.size()-1];
            end
            if (a_if.ddr_wr_en) begin
                a_addr_q.push_back(a_if.ddr_addr);
                a_data_q.push_back(a_if.ddr_wr_data);
            end
            a_prev_wr  = a_if.ddr_wr_en;
            a_prev_eow = a_if.end_of_write;
        end
    end

    int           b_count;
    int           b_bad;
    int           b_fd_count;
    logic [23:0]  b_last_addr;
    logic [127:0] b_last_data;

    always @(negedge clk) begin
        if (b_reset) begin
            b_count     = 0;
            b_bad       = 0;
            b_fd_count  = 0;
            b_last_addr = '1;
            b_last_data = '1;
        end else begin
            if (b_if.frame_done) b_fd_count++;
            if (b_if.ddr_wr_en) begin
                int n;
                n = 1003 - 5 * b_count;
                if (n > 5) n = 5;
                if (b_if.ddr_wr_data !== pack(5 * b_count + 1, n)) b_bad++;
                if (b_if.ddr_addr !== 24'(b_count)) b_bad++;
                b_last_addr = b_if.ddr_addr;
                b_last_data = b_if.ddr_wr_data;
                b_count++;
            end
        end
    end

    // ---------------- stimulus helpers (called on a falling edge) ---------
    // Offer one pixel and return on the falling edge after it is accepted.
    task automatic send(input bit use_b, input logic [23:0] p);
        int guard;
        guard = 0;
        if (use_b) begin
            b_if.pixel_in = p; b_if.pixel_valid = 1'b1;
        end else begin
            a_if.pixel_in = p; a_if.pixel_valid = 1'b1;
        end
        while (!(use_b ? b_if.pixel_ready : a_if.pixel_ready) && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            fails++;
            $error("FAIL send_timeout: pixel %0h observed no ready expected ready within 300 cycles", p);
        end
        @(negedge clk);
        if (use_b) b_if.pixel_valid = 1'b0;
        else       a_if.pixel_valid = 1'b0;
    endtask

    task automatic wait_writes_a(input int n);
        int guard;
        guard = 0;
        while (a_addr_q.size() < n && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) begin
            fails++;
            $error("FAIL a_write_timeout: observed %0d writes expected %0d", a_addr_q.size(), n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_reset_a();
        @(negedge clk);
        #2 a_reset = 1'b1;
        repeat (2) @(negedge clk);
        #2 a_reset = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------------------------
    initial begin
        bit bad;
        int guard;
        tests = 0;
        fails = 0;
        a_reset = 1'b1;
        b_reset = 1'b1;
        a_if.pixel_in = '0; a_if.pixel_valid = 1'b0; a_if.ddr_wr_busy = 1'b0;
        b_if.pixel_in = '0; b_if.pixel_valid = 1'b0; b_if.ddr_wr_busy = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ready",  a_if.pixel_ready,  1'b0);
        check("rst_wr_en",  a_if.ddr_wr_en,    1'b0);
        check("rst_addr",   a_if.ddr_addr,     24'h0);
        check("rst_fdone",  a_if.frame_done,   1'b0);
        check("rst_eow",    a_if.end_of_write, 1'b0);
        check("rst_data",   a_if.ddr_wr_data,  128'h0);
        check("wpf_default", 128'(words_per_frame(196608)), 128'd39322);
        #2 a_reset = 1'b0; b_reset = 1'b0;
        @(negedge clk);

        // Frame 0, word 0 completes while the controller is busy.
        a_if.ddr_wr_busy = 1'b1;
        for (int i = 1; i <= 5; i++) send(1'b0, 24'(i));
        bad = 1'b0;
        repeat (20) begin
            if (a_if.pixel_ready !== 1'b0 || a_if.ddr_wr_en !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        check("busy_hold_quiet", bad, 1'b0);
        check("busy_hold_no_write", a_addr_q.size(), 0);
        a_if.ddr_wr_busy = 1'b0;
        @(negedge clk);
        check("busy_release_wr_en", a_if.ddr_wr_en, 1'b1);
        check("busy_release_addr",  a_if.ddr_addr, 24'h0);
        check("word0_data", a_if.ddr_wr_data,
              {8'h0, 24'h5, 24'h4, 24'h3, 24'h2, 24'h1});

        // Word 1: latency from the fifth transfer with busy low.
        for (int i = 6; i <= 10; i++) send(1'b0, 24'(i));
        check("lat_wait_wr_en", a_if.ddr_wr_en, 1'b0);
        check("lat_wait_ready", a_if.pixel_ready, 1'b0);
        @(negedge clk);
        check("lat_issue_wr_en", a_if.ddr_wr_en, 1'b1);
        check("lat_issue_addr",  a_if.ddr_addr, 24'h1);

        // Word 2: partial flush of the frame's last two pixels.
        for (int i = 11; i <= 12; i++) send(1'b0, 24'(i));
        wait_writes_a(3);
        check("f0_write_count", a_addr_q.size(), 3);
        check("f0_addr2", a_addr_q[2], 24'h2);
        check("word2_data", a_data_q[2], {80'h0, 24'hC, 24'hB});
        check("f0_fdone_count", a_fd_count, 1);
        check("f0_fdone_after_write", a_fd_ok, 1'b1);
        check("f0_fdone_addr", a_fd_addr, 24'h2);
        check("f0_eow_low", a_if.end_of_write, 1'b0);

        // Frame 1: same stream, continuous valid, ends the clip.
        for (int i = 1; i <= 12; i++) send(1'b0, 24'(i));
        wait_writes_a(6);
        check("f1_write_count", a_addr_q.size(), 6);
        for (int w = 3; w < 6; w++) begin
            check($sformatf("f1_addr%0d", w), a_addr_q[w], 24'(w));
            check($sformatf("f1_data%0d", w), a_data_q[w],
                  (w == 5) ? pack(11, 2) : pack(5 * (w - 3) + 1, 5));
        end
        check("f1_fdone_count", a_fd_count, 2);
        check("eow_high", a_if.end_of_write, 1'b1);
        check("eow_rises_once", a_eow_rises, 1);
        check("eow_after_write", a_eow_after_wr, 1'b1);
        check("eow_after_addr5", a_eow_addr, 24'h5);

        // DONE: offered pixels are ignored for 100 cycles.
        a_if.pixel_in = 24'hABCDEF;
        a_if.pixel_valid = 1'b1;
        bad = 1'b0;
        repeat (100) begin
            if (a_if.pixel_ready !== 1'b0 || a_if.ddr_wr_en !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        a_if.pixel_valid = 1'b0;
        check("done_quiet", bad, 1'b0);
        check("done_no_more_writes", a_addr_q.size(), 6);
        check("done_eow_sticky", a_if.end_of_write, 1'b1);

        // Gappy valid: data sequence must match the continuous run.
        pulse_reset_a();
        for (int f = 0; f < 2; f++) begin
            for (int i = 1; i <= 12; i++) begin
                if ($urandom_range(0, 1) == 1) @(negedge clk);
                send(1'b0, 24'(i));
            end
        end
        wait_writes_a(6);
        check("rnd_write_count", a_addr_q.size(), 6);
        for (int w = 0; w < 6; w++) begin
            check($sformatf("rnd_data%0d", w), a_data_q[w],
                  (w % 3 == 2) ? pack(11, 2) : pack(5 * (w % 3) + 1, 5));
        end
        check("rnd_eow", a_if.end_of_write, 1'b1);

        // Reset in mid-word: 7 pixels in, word 0 written, word 1 partial.
        pulse_reset_a();
        for (int i = 1; i <= 7; i++) send(1'b0, 24'(i));
        check("mid_write_count", a_addr_q.size(), 1);
        check("mid_addr_before", a_if.ddr_addr, 24'h1);
        #2 a_reset = 1'b1;
        #1;
        check("async_rst_ready", a_if.pixel_ready, 1'b0);
        check("async_rst_wr_en", a_if.ddr_wr_en, 1'b0);
        check("async_rst_addr",  a_if.ddr_addr, 24'h0);
        check("async_rst_data",  a_if.ddr_wr_data, 128'h0);
        repeat (2) @(negedge clk);
        #2 a_reset = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 5; i++) send(1'b0, 24'(i));
        wait_writes_a(1);
        check("restart_addr", a_addr_q[0], 24'h0);
        check("restart_data", a_data_q[0], pack(1, 5));

        // Instance B: one frame with a three-pixel last word.
        for (int i = 1; i <= 1003; i++) send(1'b1, 24'(i));
        guard = 0;
        while (b_count < 201 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("b_write_count", b_count, 201);
        check("b_word_errors", b_bad, 0);
        check("b_last_addr", b_last_addr, 24'd200);
        check("b_last_data", b_last_data, pack(1001, 3));
        check("b_fdone_once", b_fd_count, 1);
        check("b_eow", b_if.end_of_write, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
